// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
// ----------------------------------------------------------------------------
// Fetch stage of the pipelined ARMv8-subset CPU. It owns the program counter,
// drives the combinational instruction-memory read address and registers the
// fetched word plus its PC into the IF/ID boundary consumed by the decoder.
// The decoder feeds back BrTaken/UncondBr/imm26/imm19 for the instruction
// currently held in IF/ID. A taken branch redirects the PC and squashes the
// wrong-path word that was being fetched in the same cycle, so every taken
// branch costs exactly one bubble.
//
// Parameters:
//   ADDR_W     PC / instruction address width in bits (must exceed 26)
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  instruction word placed in IF/ID for a bubble
//
// Ports:
//   clk          in   clock, rising-edge active
//   reset        in   asynchronous, active-high reset
//   stall        in   hold PC and IF/ID this cycle
//   BrTaken      in   branch for the IF/ID instruction is taken
//   UncondBr     in   1 selects imm26, 0 selects imm19
//   imm26        in   B-type offset in words
//   imm19        in   CB-type offset in words
//   imem_addr    out  instruction-memory address (current PC)
//   imem_rdata   in   instruction word at imem_addr, same cycle
//   instruction  out  IF/ID instruction word
//   if_pc        out  PC of the IF/ID instruction
//   if_valid     out  IF/ID holds a real instruction (0 = bubble)
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetched    out  saturating count of real instructions loaded
//   perf_redirects  out  saturating count of accepted redirects
// When FETCH_PERF_EN is undefined these ports and counters are absent.
//
// Decoder obligation: RegWrite/MemWr/FlagE must be gated with if_valid.
// ============================================================================
module instruction_fetch #(
    parameter int                 ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'hD503201F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              BrTaken,
    input  logic              UncondBr,
    input  logic [25:0]       imm26,
    input  logic [18:0]       imm19,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_redirects
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_if_valid;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_off_sext;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_redirect;
    logic              w_fetch;

    // Select and sign-extend the decoder offset to full address width.
    always_comb begin
        w_off_sext = '0;
        if (UncondBr) begin
            w_off_sext = {{(ADDR_W-26){imm26[25]}}, imm26};
        end else begin
            w_off_sext = {{(ADDR_W-19){imm19[18]}}, imm19};
        end
    end

    // Word offset becomes a byte offset; the add wraps modulo 2^ADDR_W, and
    // the two zero LSBs keep the target word-aligned relative to if_pc.
    assign w_target = r_if_pc + (w_off_sext << 2'd2);

    // Sequential next PC; wraps to 0 past the top of the address space.
    assign w_pc_inc = r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};

    // A bubble in IF/ID never redirects, and a stall defers the redirect
    // because the decoder re-presents BrTaken while the branch is held.
    assign w_redirect = (!stall) && BrTaken && r_if_valid;
    assign w_fetch    = (!stall) && (!w_redirect);

    // PC and IF/ID boundary registers, priority: reset, stall, redirect, fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (stall) begin
            r_pc       <= r_pc;
            r_instr    <= r_instr;
            r_if_pc    <= r_if_pc;
            r_if_valid <= r_if_valid;
        end else if (w_redirect) begin
            // Squash the wrong-path word fetched this cycle; if_pc keeps the
            // branch PC until the target instruction lands.
            r_pc       <= w_target;
            r_instr    <= NOP_INSTR;
            r_if_pc    <= r_if_pc;
            r_if_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_inc;
            r_instr    <= imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are straight register copies
    // ------------------------------------------------------------------
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign if_pc       = r_if_pc;
    assign if_valid    = r_if_valid;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_redirects;

    // Count real fetches and accepted redirects, holding at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched   <= 32'd0;
            r_perf_redirects <= 32'd0;
        end else begin
            if (w_fetch && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end else begin
                r_perf_fetched <= r_perf_fetched;
            end
            if (w_redirect && (r_perf_redirects != 32'hFFFF_FFFF)) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end else begin
                r_perf_redirects <= r_perf_redirects;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_redirects = r_perf_redirects;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        BrTaken;
    logic        UncondBr;
    logic [25:0] imm26;
    logic [18:0] imm19;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] if_pc;
    logic        if_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Address-tagged instruction memory: word = E0 followed by addr[23:0].
    assign imem_rdata = {8'hE0, imem_addr[23:0]};

    instruction_fetch #(
        .ADDR_W    (64),
        .RESET_PC  (64'd0),
        .NOP_INSTR (32'hD503201F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .imm26       (imm26),
        .imm19       (imm19),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    function automatic logic [31:0] tag(input logic [63:0] a);
        return {8'hE0, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [63:0] pc, input logic [63:0] ipc,
                             input logic vld, input logic [31:0] ins);
        chk({name, ".pc"},    imem_addr,          pc);
        chk({name, ".if_pc"}, if_pc,              ipc);
        chk({name, ".valid"}, {63'd0, if_valid},  {63'd0, vld});
        chk({name, ".instr"}, {32'd0, instruction}, {32'd0, ins});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        BrTaken  = 1'b0;
        UncondBr = 1'b0;
        imm26    = 26'd0;
        imm19    = 19'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 64'd0, 64'd0, 1'b0, NOP);
        reset = 1'b0;

        // Sequential fetch from RESET_PC
        chk("first_addr", imem_addr, 64'd0);
        step; chk_state("seq0", 64'd4,  64'd0,  1'b1, tag(64'd0));
        step; chk_state("seq1", 64'd8,  64'd4,  1'b1, tag(64'd4));
        step; chk_state("seq2", 64'd12, 64'd8,  1'b1, tag(64'd8));
        step; chk_state("seq3", 64'd16, 64'd12, 1'b1, tag(64'd12));
        step; chk_state("seq4", 64'd20, 64'h10, 1'b1, tag(64'h10));

        // Unconditional branch at 0x10, imm26 = 3 -> 0x1C
        BrTaken = 1'b1; UncondBr = 1'b1; imm26 = 26'd3;
        step; chk_state("b_squash", 64'h1C, 64'h10, 1'b0, NOP);
        // BrTaken left high over the bubble must be ignored
        step; chk_state("b_land", 64'h20, 64'h1C, 1'b1, tag(64'h1C));
        BrTaken = 1'b0;
        for (int i = 0; i < 9; i++) step;
        chk_state("run_to_40", 64'h44, 64'h40, 1'b1, tag(64'h40));

        // Backward CB branch at 0x40, imm19 = -2 -> 0x38
        BrTaken = 1'b1; UncondBr = 1'b0; imm19 = 19'h7FFFE;
        step; chk_state("cb_squash", 64'h38, 64'h40, 1'b0, NOP);
        BrTaken = 1'b0;
        step; chk_state("cb_land", 64'h3C, 64'h38, 1'b1, tag(64'h38));

        // Stall 3 cycles with a taken branch pending (imm26 = 8 -> 0x58)
        stall = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1; imm26 = 26'd8;
        step; chk_state("stall1", 64'h3C, 64'h38, 1'b1, tag(64'h38));
        step; chk_state("stall2", 64'h3C, 64'h38, 1'b1, tag(64'h38));
        step; chk_state("stall3", 64'h3C, 64'h38, 1'b1, tag(64'h38));
        stall = 1'b0;
        step; chk_state("stall_redir", 64'h58, 64'h38, 1'b0, NOP);
        step; chk_state("stall_land", 64'h5C, 64'h58, 1'b1, tag(64'h58));

        // Back-to-back: landed target is itself a taken branch -> 0x78
        step; chk_state("b2b_squash", 64'h78, 64'h58, 1'b0, NOP);
        BrTaken = 1'b0;
        step; chk_state("b2b_land", 64'h7C, 64'h78, 1'b1, tag(64'h78));

        // Async reset between edges while a redirect is pending
        BrTaken = 1'b1; imm26 = 26'd4;
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 64'd0, 64'd0, 1'b0, NOP);
        step; chk_state("rst_hold", 64'd0, 64'd0, 1'b0, NOP);
        reset = 1'b0; BrTaken = 1'b0;
        step; chk_state("rst_f0", 64'd4, 64'd0, 1'b1, tag(64'd0));
        step; chk_state("rst_f1", 64'd8, 64'd4, 1'b1, tag(64'd4));

        // Branch from 4 by -2 words to 2^64-4, then sequential wrap to 0
        BrTaken = 1'b1; UncondBr = 1'b0; imm19 = 19'h7FFFE;
        step; chk_state("to_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 1'b0, NOP);
        BrTaken = 1'b0;
        step; chk_state("wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, tag(64'hFFFF_FFFF_FFFF_FFFC));
        step; chk_state("wrap_next", 64'd4, 64'd0, 1'b1, tag(64'd0));

        // Most negative imm26 from if_pc 0 -> -2^27
        BrTaken = 1'b1; UncondBr = 1'b1; imm26 = 26'h2000000;
        step; chk_state("imm26_min", 64'hFFFF_FFFF_F800_0000, 64'd0, 1'b0, NOP);
        BrTaken = 1'b0;

`ifdef FETCH_PERF_EN
        // Since the last reset: fetches rst_f0, rst_f1, wrap, wrap_next;
        // redirects to_top and imm26_min.
        chk("perf_fetched",   {32'd0, perf_fetched},   64'd4);
        chk("perf_redirects", {32'd0, perf_redirects}, 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
